// File: rtl/iob_regfile_wr_arb_if.sv
// Write-side bus between the two requesting datapaths, the clear control and
// the register file write port A.
interface iob_regfile_wr_arb_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic              clr;
    logic              busy;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    // Requesters and clear source drive the bus.
    modport master (
        output req0, addr0, wdata0, req1, addr1, wdata1, clr,
        input  ack0, ack1, busy, we, addr, wdata
    );

    // The arbiter serves the bus.
    modport slave (
        input  req0, addr0, wdata0, req1, addr1, wdata1, clr,
        output ack0, ack1, busy, we, addr, wdata
    );
endinterface

// File: rtl/iob_regfile_wr_arb.sv
// Round-robin write arbiter for register file port A, with a clear sequencer
// that zeroes every entry after a one-cycle clr pulse.
module iob_regfile_wr_arb #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    iob_regfile_wr_arb_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            nextState;
    logic              last;
    logic [ADDR_W-1:0] cnt;
    logic              grant0;
    logic              grant1;
    logic              weQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;

    always_comb begin
        nextState = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                // A same-cycle clr takes priority over any pending request.
                if (bus.clr) begin
                    nextState = CLEAR;
                end else if (bus.req0 && bus.req1) begin
                    grant0 = last;
                    grant1 = ~last;
                end else begin
                    grant0 = bus.req0;
                    grant1 = bus.req1;
                end
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (rst) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    // Issue stage: winning write or clear write registered onto port A.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
        end else begin
            state <= nextState;
            if (grant0) begin
                last <= 1'b0;
            end else if (grant1) begin
                last <= 1'b1;
            end
            if (state == CLEAR) begin
                cnt    <= cnt + ADDR_W'(1);
                weQ    <= 1'b1;
                addrQ  <= cnt;
                wdataQ <= '0;
            end else if (grant0) begin
                weQ    <= 1'b1;
                addrQ  <= bus.addr0;
                wdataQ <= bus.wdata0;
            end else if (grant1) begin
                weQ    <= 1'b1;
                addrQ  <= bus.addr1;
                wdataQ <= bus.wdata1;
            end else begin
                weQ    <= 1'b0;
            end
        end
    end

    assign bus.ack0  = grant0;
    assign bus.ack1  = grant1;
    assign bus.busy  = (state == CLEAR);
    assign bus.we    = weQ;
    assign bus.addr  = addrQ;
    assign bus.wdata = wdataQ;
endmodule
